// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_W  = 4;          // operand / result width
  localparam int ITER_W = 2;          // iteration counter width (DIV_W iterations)
  localparam int SUB_W  = DIV_W + 1;  // working width of the trial subtraction

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/cla_sub_5bits.sv
// cla_sub_5bits: 5-bit subtractor X - Y = X + ~Y + 1 on a generate/propagate lookahead.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
// Ports: i_x minuend, i_y subtrahend, o_diff difference, o_borrow set when i_x < i_y.
module cla_sub_5bits
  import div_pkg::*;
(
  input  logic [SUB_W-1:0] i_x,
  input  logic [SUB_W-1:0] i_y,
  output logic [SUB_W-1:0] o_diff,
  output logic             o_borrow
);

  logic [SUB_W-1:0] w_g;
  logic [SUB_W-1:0] w_p;
  logic [SUB_W:0]   w_c;

  // Inverting Y turns the adder into a subtractor; the +1 is the carry-in.
  assign w_g    = i_x & ~i_y;
  assign w_p    = i_x ^ ~i_y;
  assign w_c[0] = 1'b1;

  // Each carry is the OR of every generate term propagated up to it, plus the
  // carry-in propagated through all lower bits -- no ripple chain.
  genvar i, j;
  for (i = 0; i < SUB_W; i++) begin : g_carry
    logic [i+1:0] w_terms;
    for (j = 0; j <= i; j++) begin : g_term
      if (j == i) begin : g_own
        assign w_terms[j] = w_g[j];
      end else begin : g_prop
        assign w_terms[j] = w_g[j] & (&w_p[i:j+1]);
      end
    end
    assign w_terms[i+1] = (&w_p[i:0]) & w_c[0];
    assign w_c[i+1]     = |w_terms;
  end

  assign o_diff   = w_p ^ w_c[SUB_W-1:0];
  // No carry out of X + ~Y + 1 means the subtraction wrapped, i.e. a borrow.
  assign o_borrow = ~w_c[SUB_W];

endmodule

// File: rtl/seq_div_4bits.sv
// seq_div_4bits: 4-bit unsigned restoring divider, one quotient bit per cycle.
// Latency: done 4 edges after capture (0 edges for divide-by-zero), one-cycle strobe.
// Backpressure: none; enable is dropped while busy, no queueing.
// Ports: clk, rst_n (sync, active-low), enable/A/B request; Qt/R/div_by_zero
//        registered results valid with done; busy high from capture until done ends.
module seq_div_4bits
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] A,
  input  logic [DIV_W-1:0] B,
  output logic [DIV_W-1:0] Qt,
  output logic [DIV_W-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  div_state_t r_state;
  div_state_t w_state_nxt;

  logic [DIV_W-1:0]  r_dvd;    // dividend shifts out MSB-first, quotient shifts in
  logic [DIV_W-1:0]  r_dvs;
  logic [DIV_W-1:0]  r_part;   // partial remainder; always < divisor, so 4 bits suffice
  logic [ITER_W-1:0] r_cnt;
  logic [DIV_W-1:0]  r_qt;
  logic [DIV_W-1:0]  r_rem;
  logic              r_dbz;

  logic              w_capture;
  logic              w_step;
  logic              w_last;
  logic [SUB_W-1:0]  w_shift;
  logic [SUB_W-1:0]  w_trial;
  logic              w_borrow;
  logic [DIV_W-1:0]  w_part_nxt;
  logic [DIV_W-1:0]  w_quot_nxt;
  logic              w_unused_trial_msb;

  // The 5-bit working value is the partial remainder shifted with the next
  // dividend bit; its MSB matters only to the subtraction.
  assign w_shift = {r_part, r_dvd[DIV_W-1]};

  cla_sub_5bits u_sub (
    .i_x      (w_shift),
    .i_y      ({1'b0, r_dvs}),
    .o_diff   (w_trial),
    .o_borrow (w_borrow)
  );

  // A successful trial is always below the divisor, so its MSB is zero; a
  // restore keeps a shifted value that was already below the divisor.
  assign w_unused_trial_msb = w_trial[SUB_W-1];
  assign w_part_nxt = w_borrow ? w_shift[DIV_W-1:0] : w_trial[DIV_W-1:0];
  assign w_quot_nxt = {r_dvd[DIV_W-2:0], ~w_borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (enable) begin
          w_capture   = 1'b1;
          w_state_nxt = (B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == ITER_W'(DIV_W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_part <= '0;
      r_cnt  <= '0;
      r_qt   <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_capture) begin
      r_dvd  <= A;
      r_dvs  <= B;
      r_part <= '0;
      r_cnt  <= '0;
      // Divide-by-zero resolves at capture; results are otherwise left alone
      // until the operation completes.
      if (B == '0) begin
        r_qt  <= DBZ_QUOTIENT;
        r_rem <= A;
        r_dbz <= 1'b1;
      end
    end else if (w_step) begin
      r_part <= w_part_nxt;
      r_dvd  <= w_quot_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_qt  <= w_quot_nxt;
        r_rem <= w_part_nxt;
        r_dbz <= 1'b0;
      end
    end
  end

  assign Qt          = r_qt;
  assign R           = r_rem;
  assign div_by_zero = r_dbz;

endmodule
